csa_stream_accumulator: RTL

//  Sequential multi-operand adder. Operands arrive one per cycle and are folded into a

---
 rtl/csa_stream_accumulator.sv | 107 ++++++++++
 1 files changed

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator
// Multi-operand adder: operands are folded one per cycle into a redundant
// (sum, carry) pair with a 3:2 carry-save step. On the last operand an
// iterative resolve phase merges the pair into one binary result, which is
// then held on a valid/ready output until the consumer accepts it.
module csa_stream_accumulator #(
  parameter int N       = 32,
  parameter int MAX_OPS = 16,
  localparam int CW     = $clog2(MAX_OPS + 1),
  localparam int W      = N + CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic [CW-1:0] out_count
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Counter compare is done one bit wider so MAX_OPS itself is representable.
  localparam logic [CW:0] MAX_CNT = (CW + 1)'(MAX_OPS);

  state_t        state, state_nxt;
  logic [W-1:0]  s, c, s_nxt, c_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  x;
  logic [CW:0]   cnt_inc;
  logic          xfer;

  // Outputs are decoded from state only; reset forces them inactive.
  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == DONE) && !rst;
  assign out_sum   = out_valid ? s : '0;
  assign out_count = out_valid ? cnt : '0;

  assign x       = {{CW{1'b0}}, in_data};
  assign xfer    = in_valid && in_ready;
  assign cnt_inc = {1'b0, cnt} + (CW + 1)'(1);

  // Next-state and datapath update; registers hold unless a phase acts.
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    c_nxt     = c;
    cnt_nxt   = cnt;
    case (state)
      ACCUM: begin
        if (xfer) begin
          s_nxt   = s ^ c ^ x;
          c_nxt   = ((s & c) | (s & x) | (c & x)) << 1;
          cnt_nxt = cnt_inc[CW-1:0];
          if (in_last || (cnt_inc == MAX_CNT)) begin
            state_nxt = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        if (c == '0) begin
          state_nxt = DONE;
        end else begin
          s_nxt = s ^ c;
          c_nxt = (s & c) << 1;
        end
      end
      DONE: begin
        if (out_ready) begin
          s_nxt     = '0;
          c_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = ACCUM;
        end
      end
      default: begin
        s_nxt     = '0;
        c_nxt     = '0;
        cnt_nxt   = '0;
        state_nxt = ACCUM;
      end
    endcase
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      s     <= '0;
      c     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      c     <= c_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
